img_bounce_ctrl: RTL and testbench

Frame-level scheduler for the HDMI image-overlay datapath. It decides where the 256x256 ROM image window sits on the 800x600 raster each frame and which border colour it carries. It advances the window origin once per frame at the last active pixel, bouncing it off the screen edges. It supports free-run, pause and single-frame step under a req/ack handshake. The video display stage consumes its outputs as the window origin and border colour instead of fixed centred constants.

---
 rtl/img_bounce_ctrl_pkg.sv | 39 +++
 rtl/bounce_axis.sv | 64 ++++++
 rtl/img_bounce_ctrl.sv | 154 +++++++++++++++
 tb/tb_img_bounce_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_bounce_ctrl_pkg.sv
// Shared definitions for the image-overlay scheduler and the video display stage:
// raster/window defaults, field widths, border palette and the scheduler state encoding.
package img_bounce_ctrl_pkg;

   localparam int unsigned H_DISP_DEF     = 800;
   localparam int unsigned V_DISP_DEF     = 600;
   localparam int unsigned IMG_WIDTH_DEF  = 256;
   localparam int unsigned IMG_HEIGHT_DEF = 256;

   localparam int unsigned POS_W   = 11;
   localparam int unsigned CALC_W  = 12;
   localparam int unsigned COLOR_W = 24;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned PAL_W   = 2;

   localparam logic [COLOR_W-1:0] PAL_RED    = 24'hFF0000;
   localparam logic [COLOR_W-1:0] PAL_GREEN  = 24'h00FF00;
   localparam logic [COLOR_W-1:0] PAL_BLUE   = 24'h0000FF;
   localparam logic [COLOR_W-1:0] PAL_YELLOW = 24'hFFFF00;

   typedef enum logic [1:0] {
      ST_CENTER = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSE  = 2'd2
   } state_t;

   // Border colour for a palette index.
   function automatic logic [COLOR_W-1:0] palette_color(input logic [PAL_W-1:0] idx);
      logic [COLOR_W-1:0] c;
      case (idx)
         2'd0:    c = PAL_RED;
         2'd1:    c = PAL_GREEN;
         2'd2:    c = PAL_BLUE;
         default: c = PAL_YELLOW;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing window origin.
// Ports: pixel_clk/sys_rst_n (clock, async active-low reset), i_advance (move one
// step this cycle), o_pos (registered origin), o_dir_neg (registered direction,
// 1 = moving toward 0), o_hit_c (combinational: this advance flips direction).
module bounce_axis
   import img_bounce_ctrl_pkg::*;
#(
   parameter int unsigned STEP    = 2,
   parameter int unsigned LIMIT   = 544,
   parameter int unsigned RST_VAL = 272
) (
   input  logic             pixel_clk,
   input  logic             sys_rst_n,
   input  logic             i_advance,
   output logic [POS_W-1:0] o_pos,
   output logic             o_dir_neg,
   output logic             o_hit_c
);

   logic [POS_W-1:0]         r_pos;
   logic                     r_dir_neg;
   logic [POS_W-1:0]         w_pos_nxt;
   logic                     w_dir_nxt;
   logic signed [CALC_W-1:0] w_nx;

   // Candidate position; clamps and flips when it reaches or passes an edge.
   always_comb begin
      w_pos_nxt = r_pos;
      w_dir_nxt = r_dir_neg;
      o_hit_c   = 1'b0;
      if (r_dir_neg)
         w_nx = signed'(CALC_W'(r_pos)) - signed'(CALC_W'(STEP));
      else
         w_nx = signed'(CALC_W'(r_pos)) + signed'(CALC_W'(STEP));
      if (i_advance) begin
         if (!r_dir_neg && (w_nx >= signed'(CALC_W'(LIMIT)))) begin
            w_pos_nxt = POS_W'(LIMIT);
            w_dir_nxt = 1'b1;
            o_hit_c   = 1'b1;
         end else if (r_dir_neg && (w_nx[CALC_W-1] || (w_nx == CALC_W'(0)))) begin
            w_pos_nxt = '0;
            w_dir_nxt = 1'b0;
            o_hit_c   = 1'b1;
         end else begin
            w_pos_nxt = POS_W'(w_nx);
         end
      end
   end

   // Position and direction registers.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pos     <= POS_W'(RST_VAL);
         r_dir_neg <= 1'b0;
      end else begin
         r_pos     <= w_pos_nxt;
         r_dir_neg <= w_dir_nxt;
      end
   end

   assign o_pos     = r_pos;
   assign o_dir_neg = r_dir_neg;

endmodule

// File: rtl/img_bounce_ctrl.sv
// Frame-level scheduler for the image-overlay window: moves the 256x256 window
// origin once per frame (at the last active pixel), bouncing off the raster edges,
// and cycles the border colour on every edge hit. Free-run / pause / single step.
// Ports: pixel_clk, sys_rst_n (async active-low); pixel_xpos/pixel_ypos (raster
// position); run_en (free-run level); step_req (step pulse); step_ack (step applied);
// frame_done (frame boundary seen); img_x_start/img_y_start (window origin);
// border_color (RGB888); bounce_cnt (edge hits, wrapping).
module img_bounce_ctrl
   import img_bounce_ctrl_pkg::*;
#(
   parameter int unsigned H_DISP     = H_DISP_DEF,
   parameter int unsigned V_DISP     = V_DISP_DEF,
   parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int unsigned DX         = 2,
   parameter int unsigned DY         = 1
) (
   input  logic               pixel_clk,
   input  logic               sys_rst_n,
   input  logic [POS_W-1:0]   pixel_xpos,
   input  logic [POS_W-1:0]   pixel_ypos,
   input  logic               run_en,
   input  logic               step_req,
   output logic               step_ack,
   output logic               frame_done,
   output logic [POS_W-1:0]   img_x_start,
   output logic [POS_W-1:0]   img_y_start,
   output logic [COLOR_W-1:0] border_color,
   output logic [CNT_W-1:0]   bounce_cnt
);

   localparam int unsigned MAX_X = H_DISP - IMG_WIDTH;
   localparam int unsigned MAX_Y = V_DISP - IMG_HEIGHT;
   localparam int unsigned RST_X = MAX_X / 2;
   localparam int unsigned RST_Y = MAX_Y / 2;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_pending;
   logic               w_pending_nxt;
   logic               w_pend_eff;
   logic               w_fb;
   logic               w_advance;
   logic               w_ack_nxt;
   logic               r_step_ack;
   logic               r_frame_done;
   logic [PAL_W-1:0]   r_pal_idx;
   logic [PAL_W-1:0]   w_pal_inc;
   logic [COLOR_W-1:0] r_border;
   logic [CNT_W-1:0]   r_bounce_cnt;
   logic               w_x_hit_c;
   logic               w_y_hit_c;
   logic               w_hit_c;
   logic               w_x_dir_neg;
   logic               w_y_dir_neg;
   logic               w_unused;

   // Last active pixel of the frame.
   assign w_fb = (pixel_xpos == POS_W'(H_DISP - 1)) && (pixel_ypos == POS_W'(V_DISP - 1));

   // A request in the boundary cycle itself still counts for this boundary.
   assign w_pend_eff = r_pending | step_req;

   // State register.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= ST_CENTER;
      else            r_state <= w_state_nxt;
   end

   // Next state, step bookkeeping and advance strobe; everything moves only at FB.
   // While running, a pending step is dropped silently: the run advance covers it.
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = w_pend_eff;
      w_advance     = 1'b0;
      w_ack_nxt     = 1'b0;
      if (w_fb) begin
         w_pending_nxt = 1'b0;
         unique case (r_state)
            ST_RUN: begin
               w_advance = run_en;
               if (!run_en) w_state_nxt = ST_PAUSE;
            end
            ST_CENTER, ST_PAUSE: begin
               w_advance = run_en | w_pend_eff;
               w_ack_nxt = w_pend_eff;
               if (run_en)          w_state_nxt = ST_RUN;
               else if (w_pend_eff) w_state_nxt = ST_PAUSE;
            end
            default: w_state_nxt = ST_CENTER;
         endcase
      end
   end

   bounce_axis #(
      .STEP    (DX),
      .LIMIT   (MAX_X),
      .RST_VAL (RST_X)
   ) u_axis_x (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .i_advance (w_advance),
      .o_pos     (img_x_start),
      .o_dir_neg (w_x_dir_neg),
      .o_hit_c   (w_x_hit_c)
   );

   bounce_axis #(
      .STEP    (DY),
      .LIMIT   (MAX_Y),
      .RST_VAL (RST_Y)
   ) u_axis_y (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .i_advance (w_advance),
      .o_pos     (img_y_start),
      .o_dir_neg (w_y_dir_neg),
      .o_hit_c   (w_y_hit_c)
   );

   // Direction is only needed inside the axes.
   assign w_unused = w_x_dir_neg ^ w_y_dir_neg;

   // A corner hit counts once.
   assign w_hit_c   = w_x_hit_c | w_y_hit_c;
   assign w_pal_inc = r_pal_idx + PAL_W'(1);

   // Pulses, pending flag, palette and hit counter.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_step_ack   <= 1'b0;
         r_frame_done <= 1'b0;
         r_pending    <= 1'b0;
         r_pal_idx    <= '0;
         r_border     <= PAL_RED;
         r_bounce_cnt <= '0;
      end else begin
         r_step_ack   <= w_ack_nxt;
         r_frame_done <= w_fb;
         r_pending    <= w_pending_nxt;
         if (w_hit_c) begin
            r_pal_idx    <= w_pal_inc;
            r_border     <= palette_color(w_pal_inc);
            r_bounce_cnt <= r_bounce_cnt + CNT_W'(1);
         end
      end
   end

   assign step_ack     = r_step_ack;
   assign frame_done   = r_frame_done;
   assign border_color = r_border;
   assign bounce_cnt   = r_bounce_cnt;

endmodule

// File: tb/tb_img_bounce_ctrl.sv
// Self-checking bench for img_bounce_ctrl (DX=4, DY=3 build) with a frame-level
// reference model. Frames are compressed: a few random non-boundary pixels, then
// the boundary pixel, then one more pixel in which the results are visible.
module tb_img_bounce_ctrl;

   localparam int H    = 800;
   localparam int V    = 600;
   localparam int DXT  = 4;
   localparam int DYT  = 3;
   localparam int MAXX = 544;
   localparam int MAXY = 344;

   logic        pixel_clk;
   logic        sys_rst_n;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic        run_en;
   logic        step_req;
   logic        step_ack;
   logic        frame_done;
   logic [10:0] img_x_start;
   logic [10:0] img_y_start;
   logic [23:0] border_color;
   logic [7:0]  bounce_cnt;

   img_bounce_ctrl #(
      .H_DISP     (H),
      .V_DISP     (V),
      .IMG_WIDTH  (256),
      .IMG_HEIGHT (256),
      .DX         (DXT),
      .DY         (DYT)
   ) dut (
      .pixel_clk    (pixel_clk),
      .sys_rst_n    (sys_rst_n),
      .pixel_xpos   (pixel_xpos),
      .pixel_ypos   (pixel_ypos),
      .run_en       (run_en),
      .step_req     (step_req),
      .step_ack     (step_ack),
      .frame_done   (frame_done),
      .img_x_start  (img_x_start),
      .img_y_start  (img_y_start),
      .border_color (border_color),
      .bounce_cnt   (bounce_cnt)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_seen = 0;
   int ack_seen = 0;

   // Reference model: origin, velocity, hit count, palette, and whether the
   // previous boundary found the block free-running.
   int m_x, m_y, m_vx, m_vy, m_cnt, m_pal, m_adv;
   bit m_in_run, m_pend, m_fd, m_ack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] pal_of(input int i);
      logic [23:0] c;
      case (i)
         0:       c = 24'hFF0000;
         1:       c = 24'h00FF00;
         2:       c = 24'h0000FF;
         default: c = 24'hFFFF00;
      endcase
      return c;
   endfunction

   function automatic void model_reset();
      m_x = MAXX / 2; m_y = MAXY / 2; m_vx = DXT; m_vy = DYT;
      m_cnt = 0; m_pal = 0; m_adv = 0;
      m_in_run = 0; m_pend = 0; m_fd = 0; m_ack = 0;
   endfunction

   function automatic void model_move();
      bit hit = 0;
      m_x += m_vx;
      if (m_x >= MAXX)   begin m_x = MAXX; m_vx = -DXT; hit = 1; end
      else if (m_x <= 0) begin m_x = 0;    m_vx =  DXT; hit = 1; end
      m_y += m_vy;
      if (m_y >= MAXY)   begin m_y = MAXY; m_vy = -DYT; hit = 1; end
      else if (m_y <= 0) begin m_y = 0;    m_vy =  DYT; hit = 1; end
      if (hit) begin
         m_cnt = (m_cnt + 1) % 256;
         m_pal = (m_pal + 1) % 4;
      end
      m_adv++;
   endfunction

   function automatic void model_fb(input bit run);
      bit adv;
      if (m_in_run) adv = run;
      else begin
         adv   = run | m_pend;
         m_ack = m_pend;
      end
      m_in_run = run;
      m_pend   = 0;
      m_fd     = 1;
      if (adv) model_move();
   endfunction

   task automatic check_all();
      chk("img_x_start", 32'(img_x_start), 32'(m_x));
      chk("img_y_start", 32'(img_y_start), 32'(m_y));
      chk("border_color", 32'(border_color), 32'(pal_of(m_pal)));
      chk("bounce_cnt", 32'(bounce_cnt), 32'(m_cnt));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("step_ack", 32'(step_ack), 32'(m_ack));
      if (frame_done === 1'b1) fd_seen++;
      if (step_ack === 1'b1) ack_seen++;
   endtask

   // One pixel clock: check what the previous cycle produced, then drive this one.
   task automatic tick(input int xp, input int yp, input bit req, input bit run);
      @(negedge pixel_clk);
      check_all();
      pixel_xpos = 11'(xp);
      pixel_ypos = 11'(yp);
      step_req   = req;
      run_en     = run;
      if (req) m_pend = 1;
      m_fd  = 0;
      m_ack = 0;
      if (xp == H - 1 && yp == V - 1) model_fb(run);
   endtask

   // run_en wanders inside the frame and settles to 'run' for the boundary.
   task automatic frame(input bit run, input int n_req, input bit fb_req);
      int n_pre;
      n_pre = 2 * n_req + int'($urandom_range(1, 4));
      for (int i = 0; i < n_pre; i++)
         tick(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 2)),
              (i < 2 * n_req) && (i % 2 == 0), 1'($urandom_range(0, 1)));
      tick(H - 1, V - 1, fb_req, run);
      tick(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 2)), 1'b0, run);
   endtask

   task automatic do_reset();
      @(negedge pixel_clk);
      sys_rst_n  = 1'b0;
      pixel_xpos = '0;
      pixel_ypos = '0;
      run_en     = 1'b0;
      step_req   = 1'b0;
      model_reset();
      @(negedge pixel_clk);
      check_all();
      sys_rst_n = 1'b1;
   endtask

   initial begin
      sys_rst_n  = 1'b0;
      pixel_xpos = '0;
      pixel_ypos = '0;
      run_en     = 1'b0;
      step_req   = 1'b0;
      model_reset();

      // Reset and hold for three paused frames.
      do_reset();
      chk("rst_x", 32'(img_x_start), 32'd272);
      chk("rst_y", 32'(img_y_start), 32'd172);
      chk("rst_border", 32'(border_color), 32'h00FF0000);
      fd_seen = 0; ack_seen = 0;
      for (int f = 0; f < 3; f++) frame(1'b0, 0, 1'b0);
      chk("hold_fd_count", 32'(fd_seen), 32'd3);
      chk("hold_ack_count", 32'(ack_seen), 32'd0);
      chk("hold_x", 32'(img_x_start), 32'd272);
      chk("hold_y", 32'(img_y_start), 32'd172);

      // Free run through both edges and up to the first corner hit.
      do_reset();
      for (int a = 1; a <= 748; a++) begin
         frame(1'b1, 0, 1'b0);
         if (a == 57)  chk("y_before_clamp", 32'(img_y_start), 32'd343);
         if (a == 58) begin
            chk("y_clamped", 32'(img_y_start), 32'd344);
            chk("y_hit_cnt", 32'(bounce_cnt), 32'd1);
            chk("y_hit_border", 32'(border_color), 32'h0000FF00);
         end
         if (a == 68)  chk("x_at_edge", 32'(img_x_start), 32'd544);
         if (a == 69) begin
            chk("x_bounced", 32'(img_x_start), 32'd540);
            chk("x_hit_cnt", 32'(bounce_cnt), 32'd2);
            chk("x_hit_border", 32'(border_color), 32'h000000FF);
         end
         if (a == 747) chk("pre_corner_cnt", 32'(bounce_cnt), 32'd11);
         if (a == 748) begin
            chk("corner_x", 32'(img_x_start), 32'd0);
            chk("corner_y", 32'(img_y_start), 32'd344);
            chk("corner_cnt", 32'(bounce_cnt), 32'd12);
            chk("corner_border", 32'(border_color), 32'h00FF0000);
         end
      end

      // Paused stepping: coalesced requests, idle frame, request on the boundary.
      do_reset();
      ack_seen = 0;
      frame(1'b0, 3, 1'b0);
      chk("step_x", 32'(img_x_start), 32'd276);
      chk("step_y", 32'(img_y_start), 32'd175);
      chk("step_ack_count", 32'(ack_seen), 32'd1);
      frame(1'b0, 0, 1'b0);
      chk("idle_x", 32'(img_x_start), 32'd276);
      chk("idle_ack_count", 32'(ack_seen), 32'd1);
      frame(1'b0, 0, 1'b1);
      chk("fb_step_x", 32'(img_x_start), 32'd280);
      chk("fb_step_ack_count", 32'(ack_seen), 32'd2);

      // Random mix of run, pause and steps against the model.
      for (int f = 0; f < 400; f++)
         frame(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));

      // Reset in the middle of a running frame.
      for (int f = 0; f < 5; f++) frame(1'b1, 0, 1'b0);
      tick(400, 300, 1'b0, 1'b1);
      #2 sys_rst_n = 1'b0;
      #1 model_reset();
      check_all();
      chk("midrst_x", 32'(img_x_start), 32'd272);
      chk("midrst_y", 32'(img_y_start), 32'd172);
      chk("midrst_border", 32'(border_color), 32'h00FF0000);
      @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      frame(1'b0, 0, 1'b0);
      chk("post_rst_hold_x", 32'(img_x_start), 32'd272);
      frame(1'b1, 0, 1'b0);
      chk("post_rst_run_x", 32'(img_x_start), 32'd276);
      chk("post_rst_run_y", 32'(img_y_start), 32'd175);
      tick(0, 0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
